// File: rtl/change_return_sequencer_if.sv
// Handshake bundle between the timer/total stage and the change-return sequencer.
// The master side drives the return request, timer value and balance.
interface change_return_sequencer_if #(
    parameter int kNumCoins = 3
);
    logic                 i_trigger_return;
    logic [31:0]          wait_time;
    logic [31:0]          i_balance;
    logic                 o_clear_total;
    logic [kNumCoins-1:0] o_return_coin;
    logic                 o_busy;
    logic                 o_done;
    logic [31:0]          o_residual;

    modport master (
        output i_trigger_return, wait_time, i_balance,
        input  o_clear_total, o_return_coin, o_busy, o_done, o_residual
    );

    modport slave (
        input  i_trigger_return, wait_time, i_balance,
        output o_clear_total, o_return_coin, o_busy, o_done, o_residual
    );
endinterface

// File: rtl/change_return_sequencer.sv
// Latches the balance on a return request or timer expiry, then pays it back
// greedily (one coin per clock) and finishes with a done pulse carrying the residual.
module change_return_sequencer #(
    parameter int          kNumCoins = 3,
    parameter logic [31:0] COIN_VAL0 = 32'd100,
    parameter logic [31:0] COIN_VAL1 = 32'd500,
    parameter logic [31:0] COIN_VAL2 = 32'd1000
) (
    input logic                      clk,
    input logic                      reset_n,
    change_return_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PAY, DONE} state_t;

    state_t               state_q;
    logic [31:0]          rem_q;
    logic                 clear_q, busy_q, done_q;
    logic [kNumCoins-1:0] coin_q;
    logic [31:0]          residual_q;

    function automatic logic [31:0] coin_val(input int k);
        case (k)
            0:       return COIN_VAL0;
            1:       return COIN_VAL1;
            default: return COIN_VAL2;
        endcase
    endfunction

    // A wrapped (negative) timer counts as expired.
    logic timeout, start;
    assign timeout = (bus.wait_time == 32'd0) || bus.wait_time[31];
    assign start   = (bus.i_trigger_return || timeout) && (bus.i_balance != 32'd0);

    // Ascending scan; the last coin that fits is the largest.
    logic                 fit;
    logic [kNumCoins-1:0] fit_oh;
    logic [31:0]          fit_val;
    always_comb begin
        fit     = 1'b0;
        fit_oh  = '0;
        fit_val = '0;
        for (int k = 0; k < kNumCoins; k++) begin
            if (coin_val(k) <= rem_q) begin
                fit       = 1'b1;
                fit_oh    = '0;
                fit_oh[k] = 1'b1;
                fit_val   = coin_val(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            clear_q    <= 1'b0;
            coin_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            residual_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    coin_q <= '0;
                    done_q <= 1'b0;
                    if (start) begin
                        rem_q   <= bus.i_balance;
                        clear_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= PAY;
                    end else begin
                        clear_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                PAY: begin
                    clear_q <= 1'b0;
                    if (fit) begin
                        coin_q <= fit_oh;
                        rem_q  <= rem_q - fit_val;
                    end else begin
                        coin_q     <= '0;
                        residual_q <= rem_q;
                        done_q     <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_clear_total = clear_q;
    assign bus.o_return_coin = coin_q;
    assign bus.o_busy        = busy_q;
    assign bus.o_done        = done_q;
    assign bus.o_residual    = residual_q;
endmodule

// File: tb/tb_change_return_sequencer.sv
// Randomised and directed bench for change_return_sequencer; expected payouts come
// from a greedy division model of the coin set.
module tb_change_return_sequencer;
    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] vals [3] = '{32'd100, 32'd500, 32'd1000};

    always #5 clk = ~clk;

    change_return_sequencer_if #(.kNumCoins(3)) bus ();

    change_return_sequencer #(.kNumCoins(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_trigger_return = 1'b0;
        bus.wait_time        = 32'd100;
        bus.i_balance        = 32'd0;
    endtask

    // Called #1 after the start edge; walks clear, coins, done and return to idle.
    task automatic expect_payout(input logic [31:0] bal, input string tag);
        int          q[$];
        logic [31:0] rem;
        logic [5:0]  obs, exp;
        rem = bal;
        for (int k = 2; k >= 0; k--) begin
            int n;
            n = int'(rem / vals[k]);
            repeat (n) q.push_back(k);
            rem = rem % vals[k];
        end
        obs = {bus.o_clear_total, bus.o_return_coin, bus.o_busy, bus.o_done};
        exp = {1'b1, 3'b000, 1'b1, 1'b0};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s start: got %b want %b", tag, obs, exp);
        end
        foreach (q[i]) begin
            step();
            obs = {bus.o_clear_total, bus.o_return_coin, bus.o_busy, bus.o_done};
            exp = {1'b0, 3'(3'b001 << q[i]), 1'b1, 1'b0};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL %s coin%0d: got %b want %b", tag, i, obs, exp);
            end
        end
        step();
        obs = {bus.o_clear_total, bus.o_return_coin, bus.o_busy, bus.o_done};
        exp = {1'b0, 3'b000, 1'b1, 1'b1};
        n_checks++;
        if (obs !== exp || bus.o_residual !== rem) begin
            n_fail++;
            $display("FAIL %s done: got %b res %0d want %b res %0d", tag, obs, bus.o_residual, exp, rem);
        end
        step();
        obs = {bus.o_clear_total, bus.o_return_coin, bus.o_busy, bus.o_done};
        exp = 6'b0;
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s end: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic expect_quiet(input int cycles, input string tag);
        logic [5:0] obs;
        for (int i = 0; i < cycles; i++) begin
            step();
            obs = {bus.o_clear_total, bus.o_return_coin, bus.o_busy, bus.o_done};
            n_checks++;
            if (obs !== 6'b0) begin
                n_fail++;
                $display("FAIL %s quiet%0d: got %b want 000000", tag, i, obs);
            end
        end
    endtask

    task automatic test_reset();
        reset_n              = 1'b0;
        bus.i_trigger_return = 1'b1;
        bus.wait_time        = 32'd100;
        bus.i_balance        = 32'd1600;
        for (int i = 0; i < 2; i++) begin
            logic [37:0] obs;
            step();
            obs = {bus.o_clear_total, bus.o_return_coin, bus.o_busy, bus.o_done, bus.o_residual};
            n_checks++;
            if (obs !== 38'd0) begin
                n_fail++;
                $display("FAIL reset%0d: got %h want 0", i, obs);
            end
        end
        idle_inputs();
        reset_n = 1'b1;
        expect_quiet(2, "post_reset");
    endtask

    task automatic test_return_greedy();
        bus.i_balance        = 32'd1600;
        bus.i_trigger_return = 1'b1;
        step();
        idle_inputs();
        expect_payout(32'd1600, "greedy");
    endtask

    task automatic test_timeout_residual();
        bus.i_balance = 32'd250;
        bus.wait_time = 32'd2;
        expect_quiet(1, "tmo_wt2");
        bus.wait_time = 32'd1;
        expect_quiet(1, "tmo_wt1");
        bus.wait_time = 32'd0;
        step();
        idle_inputs();
        expect_payout(32'd250, "timeout");
    endtask

    task automatic test_wrapped_unpayable();
        bus.wait_time = 32'hFFFF_FFFF;
        bus.i_balance = 32'd40;
        step();
        idle_inputs();
        expect_payout(32'd40, "wrapped");
    endtask

    task automatic test_ignore_during_pay();
        bus.i_balance        = 32'd3000;
        bus.i_trigger_return = 1'b1;
        step();
        bus.i_balance = 32'd500;  // trigger stays high throughout PAY/DONE
        expect_payout(32'd3000, "ignore");
        bus.i_balance = 32'd0;
        expect_quiet(3, "ignore_norestart");
        idle_inputs();
    endtask

    task automatic test_reset_midpay_zero();
        logic [37:0] obs;
        bus.i_balance        = 32'd1600;
        bus.i_trigger_return = 1'b1;
        step();
        idle_inputs();
        step();
        n_checks++;
        if (bus.o_return_coin !== 3'b100) begin
            n_fail++;
            $display("FAIL midpay first coin: got %b want 100", bus.o_return_coin);
        end
        reset_n = 1'b0;
        step();
        obs = {bus.o_clear_total, bus.o_return_coin, bus.o_busy, bus.o_done, bus.o_residual};
        n_checks++;
        if (obs !== 38'd0) begin
            n_fail++;
            $display("FAIL midpay reset: got %h want 0", obs);
        end
        reset_n = 1'b1;
        expect_quiet(5, "midpay_after");
        bus.i_trigger_return = 1'b1;
        bus.wait_time        = 32'd0;
        expect_quiet(4, "zero_balance");
        idle_inputs();
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            logic [31:0] bal;
            int          mode;
            bal  = 32'($urandom_range(1, 4000));
            mode = $urandom_range(0, 2);
            bus.i_balance = bal;
            case (mode)
                0:       bus.i_trigger_return = 1'b1;
                1:       bus.wait_time = 32'd0;
                default: bus.wait_time = 32'h8000_0000 | 32'($urandom);
            endcase
            step();
            idle_inputs();
            expect_payout(bal, $sformatf("rand%0d", it));
        end
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        test_reset();
        test_return_greedy();
        test_timeout_residual();
        test_wrapped_unpayable();
        test_ignore_during_pay();
        test_reset_midpay_zero();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
